// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: rebuilds four W-bit channels and whole frames.
// Optional parity checking is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux4 #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic           din_par,
  output logic           par_err,
`endif
  output logic [4*W-1:0] ch_data,
  output logic [3:0]     ch_valid,
  output logic [4*W-1:0] frame_data,
  output logic           frame_valid,
  output logic [1:0]     slot,
  output logic           locked,
  output logic           sync_err
);

  logic [3:0][W-1:0] ch_q, ch_d;
  logic [2:0][W-1:0] shadow_q, shadow_d;
  logic [3:0][W-1:0] frame_q, frame_d;
  logic [3:0]        ch_valid_q, ch_valid_d;
  logic              frame_valid_q, frame_valid_d;
  logic [1:0]        slot_q, slot_d;
  logic              locked_q, locked_d;
  logic              sync_err_q, sync_err_d;
  // Slots 0..2 written cleanly since the last slot-0 beat.
  logic [2:0]        mask_q, mask_d;
  logic              par_err_q, par_err_d;

  logic              accept;
  logic              bad_beat;
  logic [1:0]        wslot;

  assign accept = din_valid & (locked_q | frame_sync);

`ifdef TDM_DEMUX_PARITY_EN
  assign bad_beat = ^{din, din_par};
  assign par_err  = par_err_q;
`else
  assign bad_beat = 1'b0;
`endif

  always_comb begin
    ch_d          = ch_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    ch_valid_d    = 4'b0000;
    frame_valid_d = 1'b0;
    slot_d        = slot_q;
    locked_d      = locked_q;
    sync_err_d    = 1'b0;
    mask_d        = mask_q;
    par_err_d     = 1'b0;
    wslot         = slot_q;

    if (accept) begin
      // frame_sync always realigns to slot 0; flag it only if we were mid-frame.
      if (frame_sync) begin
        wslot = 2'd0;
        if (locked_q && (slot_q != 2'd0)) begin
          sync_err_d = 1'b1;
        end
      end
      slot_d    = wslot + 2'd1;
      locked_d  = 1'b1;
      par_err_d = bad_beat;
      if (wslot == 2'd0) begin
        mask_d = 3'b000;
      end
      if (!bad_beat) begin
        ch_d[wslot]       = din;
        ch_valid_d[wslot] = 1'b1;
        if (wslot != 2'd3) begin
          shadow_d[wslot] = din;
          mask_d[wslot]   = 1'b1;
        end else if (&mask_q) begin
          frame_d       = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
          frame_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q          <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      ch_valid_q    <= 4'b0000;
      frame_valid_q <= 1'b0;
      slot_q        <= 2'd0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      mask_q        <= 3'b000;
      par_err_q     <= 1'b0;
    end else begin
      ch_q          <= ch_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      ch_valid_q    <= ch_valid_d;
      frame_valid_q <= frame_valid_d;
      slot_q        <= slot_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      mask_q        <= mask_d;
      par_err_q     <= par_err_d;
    end
  end

  assign ch_data     = ch_q;
  assign ch_valid    = ch_valid_q;
  assign frame_data  = frame_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the 4-to-1 time-division link: reconstructs four W-bit channels from the serialized stream a rotating 4x1 mux produces.
- Tracks slot position with a 2-bit counter aligned by frame_sync.
- Drives a per-channel registered output and valid strobe, plus a double-buffered full-frame output.
- Sits directly after the link register, ahead of per-channel consumers.

Parameters:
- W, 4, data width of one channel/slot.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  W  serialized slot data.
- din_valid  input  1  din carries a slot beat this cycle.
- frame_sync  input  1  qualifies with din_valid; marks current beat as slot 0.
- ch_data  output  4*W  per-channel hold registers; ch k at bits [k*W +: W].
- ch_valid  output  4  one-cycle pulse, bit k set when channel k updated.
- frame_data  output  4*W  last complete frame, same packing as ch_data.
- frame_valid  output  1  one-cycle pulse when frame_data updates.
- slot  output  2  slot index expected for the next beat.
- locked  output  1  aligned to a frame boundary.
- sync_err  output  1  one-cycle pulse on misaligned frame_sync.

Behaviour:
- Reset: ch_data=0, ch_valid=0, frame_data=0, frame_valid=0, slot=0, locked=0, sync_err=0. Internal shadow=0.
- Reset asserted mid-frame discards the partial frame. No frame_valid is issued for it.
- All outputs are registered. A beat accepted at edge N is visible after edge N (1-cycle latency).
- Accepted beat: din_valid=1 and (locked=1 or frame_sync=1).
- Beats with din_valid=1, frame_sync=0, locked=0 are dropped. They produce no strobes and leave slot unchanged.
- din_valid=0: no state change except pulses clearing to 0. frame_sync is ignored.
- Unlocked state (locked=0):
  - Waits for din_valid & frame_sync.
  - On that beat: write ch0, ch_valid=0001, slot<=1, locked<=1.
- Locked state:
  - Beat with frame_sync=0 writes channel slot, sets ch_valid bit slot, slot<=slot+1 (wrap 3->0).
  - Beat with frame_sync=1 and slot==0 is normal slot-0 write, no error.
  - Beat with frame_sync=1 and slot!=0:
    - sync_err pulse.
    - Partial frame abandoned (no frame_valid).
    - Beat written to ch0, slot<=1, locked stays 1.
- Shadow/frame:
  - Each accepted beat also writes shadow slot.
  - On the accepted slot-3 beat: frame_data<={din, shadow[2], shadow[1], shadow[0]}, frame_valid=1 in the same cycle ch_valid=1000.
  - frame_valid is only issued when slots 0-3 were all written since the last slot-0 beat.
- ch_data channels hold value until rewritten. frame_data holds until next complete frame.
- ch_valid, frame_valid, sync_err each default to 0 every cycle unless set as above.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Adds input din_par (1, even parity over din) and output par_err (1, reset 0, one-cycle pulse).
  - Accepted beat with ^{din,din_par}=1:
    - par_err=1.
    - Channel and shadow not written; ch_valid bit not set.
    - slot still advances.
    - If the bad beat is slot 3, frame_valid is suppressed for that frame.
  - Sync/lock handling unchanged.
- Undefined: din_par and par_err ports absent. All beats treated as good.

Test Plan:
- Reset then din_valid beats 1,2,5,7 with frame_sync on first -> ch_valid 0001,0010,0100,1000 on successive cycles; frame_data=16'h7521 with frame_valid on 4th; slot 1,2,3,0.
- Beats 3,4 with frame_sync=0 after reset -> dropped, locked=0, no strobes; then sync beat 8 -> ch0=8, locked=1.
- Locked, slot=2, beat 9 with frame_sync=1 -> sync_err pulse, ch0=9, slot=1, no frame_valid; next full frame 9,A,B,C -> frame_data=16'hCBA9.
- din_valid gaps between every beat of frame 1,2,3,4 -> identical results to back-to-back, frame_data=16'h4321, no spurious pulses during gaps.
- rst asserted after slot-1 beat, then sync frame 8,8,8,8 -> all outputs 0 during reset, frame_data=16'h8888 only after new full frame.
- TDM_DEMUX_PARITY_EN: frame 1,2,5,7 with bad parity on slot 3 -> par_err pulse, ch3 unchanged, frame_valid suppressed, slot wraps to 0.
